// File: rtl/alu_muldiv_seq_if.sv
// Request/response and shared-ALU borrow signals of the mul/div sequencer.
// slave: sequencer side (alu_muldiv_seq); master: EX stage / requester side.
// Carries in_*/out_* handshakes plus alu_en/alu_a/alu_b/alu_op/alu_out.
`ifndef ADD_op
`define ADD_op 3'b000
`endif
`ifndef SUB_op
`define SUB_op 3'b001
`endif

interface alu_muldiv_seq_if #(parameter int W = 16);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         alu_en;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_out;

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready, alu_out,
        output in_ready, out_valid, out_result, alu_en, alu_a, alu_b, alu_op
    );

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready, alu_out,
        input  in_ready, out_valid, out_result, alu_en, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Unsigned MUL / DIVU / REMU sequencer borrowing the shared ALU adder, one bit per cycle.
// Latency: W+1 cycles accept->out_valid (1 cycle for divide-by-zero / reserved op).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush aborts.
// Ports: clk, rst (sync, active high), flush (sync abort), bus (alu_muldiv_seq_if.slave).
module alu_muldiv_seq #(
    parameter int CPU_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    alu_muldiv_seq_if.slave    bus
);
    localparam int W  = CPU_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q,  op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;   // MUL accumulator / DIV partial remainder
    logic [W-1:0]  x_q,   x_d;     // MUL multiplicand / DIV dividend (both shift left)
    logic [W-1:0]  y_q,   y_d;     // MUL multiplier (shifts right) / DIV divisor
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  res_q, res_d;

    logic [W:0]    sh;             // remainder with next dividend bit shifted in
    logic          sub_ok;
    logic [W-1:0]  acc_nx;
    logic [W-1:0]  quo_nx;

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = res_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        x_d        = x_q;
        y_d        = y_q;
        quo_d      = quo_q;
        res_d      = res_q;
        bus.alu_en = 1'b0;
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_op = `ADD_op;
        sh         = {acc_q, x_q[W-1]};
        // The full W+1-bit compare is needed: sh can exceed any W-bit divisor.
        sub_ok     = (sh >= {1'b0, y_q});
        acc_nx     = acc_q;
        quo_nx     = quo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && !flush) begin
                    op_d  = bus.in_op;
                    x_d   = bus.in_a;
                    y_d   = bus.in_b;
                    acc_d = '0;
                    quo_d = '0;
                    cnt_d = '0;
                    if (bus.in_op == OP_MUL) begin
                        state_d = RUN;
                    end else if (bus.in_op == OP_DIVU || bus.in_op == OP_REMU) begin
                        if (bus.in_b == '0) begin
                            // Divide by zero resolves without touching the ALU.
                            state_d = DONE;
                            res_d   = (bus.in_op == OP_DIVU) ? '1 : bus.in_a;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = DONE;
                        res_d   = '0;
                    end
                end
            end
            RUN: begin
                bus.alu_en = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    bus.alu_a = acc_q;
                    bus.alu_b = x_q;
                    acc_nx    = y_q[0] ? bus.alu_out : acc_q;
                    x_d       = x_q << 1;
                    y_d       = y_q >> 1;
                end else begin
                    bus.alu_a  = sh[W-1:0];
                    bus.alu_b  = y_q;
                    bus.alu_op = `SUB_op;
                    acc_nx     = sub_ok ? bus.alu_out : sh[W-1:0];
                    quo_nx     = {quo_q[W-2:0], sub_ok};
                    x_d        = x_q << 1;
                end
                acc_d = acc_nx;
                quo_d = quo_nx;
                if (cnt_q == CW'(W-1)) begin
                    state_d = DONE;
                    res_d   = (op_q == OP_DIVU) ? quo_nx : acc_nx;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            quo_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed literal cases plus random ops against a transaction model.
module tb_alu_muldiv_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_muldiv_seq_if #(.W(W)) bus ();

    alu_muldiv_seq #(.CPU_WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    // Shared ALU stand-in.
    assign bus.alu_out = (bus.alu_op == `SUB_op) ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_res(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            2'b00:   return p[15:0];
            2'b01:   return (b == 0) ? 16'hFFFF : a / b;
            2'b10:   return (b == 0) ? a : a % b;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit ref_runs(input logic [1:0] op, input logic [15:0] b);
        return (op == 2'b00) || ((op == 2'b01 || op == 2'b10) && b != 0);
    endfunction

    // phase: 0 waiting for a request, 1 busy on the ALU, 2 holding a result
    int          m_phase = 0;
    int          m_left  = 0;
    logic [15:0] m_res   = 16'h0;
    logic [1:0]  m_op    = 2'b00;

    always @(posedge clk) begin
        if (rst || flush) begin
            m_phase = 0;
            if (rst) m_res = 16'h0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    m_op  = bus.in_op;
                    m_res = ref_res(bus.in_op, bus.in_a, bus.in_b);
                    if (ref_runs(bus.in_op, bus.in_b)) begin
                        m_phase = 1;
                        m_left  = W;
                    end else begin
                        m_phase = 2;
                    end
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (bus.out_ready) m_phase = 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  32'(bus.in_ready),  32'(m_phase == 0));
            chk("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
            chk("alu_en",    32'(bus.alu_en),    32'(m_phase == 1));
            if (m_phase == 2) chk("out_result", 32'(bus.out_result), 32'(m_res));
            if (m_phase == 1) begin
                chk("alu_op run", 32'(bus.alu_op), (m_op == 2'b00) ? 32'(`ADD_op) : 32'(`SUB_op));
            end else begin
                chk("alu_a idle",  32'(bus.alu_a),  32'h0);
                chk("alu_b idle",  32'(bus.alu_b),  32'h0);
                chk("alu_op idle", 32'(bus.alu_op), 32'(`ADD_op));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int t;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("accept timeout", 32'(t), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Runs one op; lat is cycles from the accept cycle to the first out_valid cycle.
    task automatic do_op(input string nm, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] lit, input int exp_lat, input int stall, input bit pin);
        int lat;
        int en_cnt;
        send(op, a, b);
        lat    = 1;
        en_cnt = int'(bus.alu_en);
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            en_cnt += int'(bus.alu_en);
        end
        if (!bus.out_valid) chk({nm, " result timeout"}, 32'(lat), 32'(exp_lat));
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " alu_en cycles"}, 32'(en_cnt), 32'(exp_lat - 1));
        chk(nm, 32'(bus.out_result), 32'(lit));
        if (pin) chk({nm, " model"}, 32'(m_res), 32'(lit));
        repeat (stall) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic flush_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input int r);
        send(op, a, b);
        repeat (r) @(negedge clk);
        flush        = 1'b1;
        bus.in_valid = 1'b1;           // must be ignored in the flush cycle
        bus.in_op    = 2'b00;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush in_ready",  32'(bus.in_ready),  32'd1);
        chk("flush out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_a      = 16'h0;
        bus.in_b      = 16'h0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset in_ready",   32'(bus.in_ready),   32'd1);
        chk("reset out_valid",  32'(bus.out_valid),  32'd0);
        chk("reset out_result", 32'(bus.out_result), 32'h0);
        chk("reset alu_en",     32'(bus.alu_en),     32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("MUL 7*9",           2'b00, 16'd7,    16'd9,    16'h003F, W+1, 0, 1'b1);
        do_op("MUL ffff*ffff",     2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, W+1, 1, 1'b1);
        do_op("MUL 100*100",       2'b00, 16'h0100, 16'h0100, 16'h0000, W+1, 0, 1'b1);
        do_op("DIVU 100/7",        2'b01, 16'd100,  16'd7,    16'h000E, W+1, 0, 1'b1);
        do_op("REMU 100/7",        2'b10, 16'd100,  16'd7,    16'h0002, W+1, 2, 1'b1);
        do_op("DIVU ffff/1",       2'b01, 16'hFFFF, 16'h0001, 16'hFFFF, W+1, 0, 1'b1);
        do_op("REMU 8000/ffff",    2'b10, 16'h8000, 16'hFFFF, 16'h8000, W+1, 0, 1'b1);
        do_op("DIVU 5/0",          2'b01, 16'd5,    16'd0,    16'hFFFF, 1,   0, 1'b1);
        do_op("REMU 5/0",          2'b10, 16'd5,    16'd0,    16'h0005, 1,   1, 1'b1);
        do_op("reserved op",       2'b11, 16'h1234, 16'h5678, 16'h0000, 1,   0, 1'b1);

        // Flush at the fifth RUN cycle, then a fresh multiply.
        flush_op(2'b00, 16'h00AA, 16'h0055, 4);
        do_op("MUL 3*4 after flush", 2'b00, 16'd3, 16'd4, 16'h000C, W+1, 0, 1'b1);

        // Reset in the middle of a divide.
        send(2'b01, 16'd1000, 16'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst in_ready",   32'(bus.in_ready),   32'd1);
        chk("rst out_valid",  32'(bus.out_valid),  32'd0);
        chk("rst out_result", 32'(bus.out_result), 32'h0);
        chk("rst alu_en",     32'(bus.alu_en),     32'd0);

        // Backpressure: result held, new request refused until the cycle after out_ready.
        send(2'b00, 16'h1234, 16'h0003);
        begin
            int t;
            t = 0;
            while (!bus.out_valid && t < 40) begin
                @(negedge clk);
                t++;
            end
            chk("bp result", 32'(bus.out_result), 32'h369C);
        end
        bus.in_op    = 2'b01;
        bus.in_a     = 16'd100;
        bus.in_b     = 16'd7;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp held result", 32'(bus.out_result), 32'h369C);
            chk("bp in_ready low", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp in_ready after ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp accepted", 32'(bus.in_ready), 32'd0);
        begin
            int t;
            t = 0;
            while (!bus.out_valid && t < 40) begin
                @(negedge clk);
                t++;
            end
            chk("bp DIVU 100/7", 32'(bus.out_result), 32'h000E);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Random traffic; the per-cycle compare against the model does the checking.
        for (int n = 0; n < 80; n++) begin
            logic [1:0]  op;
            logic [15:0] a;
            logic [15:0] b;
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            case ($urandom_range(0, 4))
                0:       b = 16'h0;
                1:       b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) begin
                flush_op(op, a, b, int'($urandom_range(0, 20)));
            end else begin
                do_op("random op", op, a, b, ref_res(op, a, b),
                      ref_runs(op, b) ? W+1 : 1, int'($urandom_range(0, 3)), 1'b0);
            end
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
